// File: rtl/router_pkg.sv
// Shared router encodings: port directions and 2x2 node output indices.
package router_pkg;

    // Desired-port field encoding carried in every flit
    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    localparam int NUM_PORTS = 4;

    // Output indices of a 2x2 node; the steering bit selects between them
    localparam logic OUT_IDX0 = 1'b0;
    localparam logic OUT_IDX1 = 1'b1;

endpackage

// File: rtl/perm_node.sv
// 2x2 deflection node: age-based arbiter with round-robin tie break and an
// exchanger that steers the winner by one bit of its desired-port field.
module perm_node
    import router_pkg::*;
#(
    parameter int FLIT_W  = 32,
    parameter int DIR_LSB = 4,
    parameter int AGE_LSB = 8,
    parameter int AGE_W   = 4,
    parameter int SEL_BIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] in0_flit,
    input  logic              in0_valid,
    input  logic [FLIT_W-1:0] in1_flit,
    input  logic              in1_valid,
    output logic [FLIT_W-1:0] out0_flit,
    output logic              out0_valid,
    output logic [FLIT_W-1:0] out1_flit,
    output logic              out1_valid
);

    logic             ptr;
    logic [AGE_W-1:0] age0;
    logic [AGE_W-1:0] age1;
    logic             tie;
    logic             pick1;
    logic             steer;
    logic [FLIT_W-1:0] win_flit;
    logic [FLIT_W-1:0] lose_flit;
    logic              lose_valid;

    assign age0 = in0_flit[AGE_LSB +: AGE_W];
    assign age1 = in1_flit[AGE_LSB +: AGE_W];

    // Pick the winner (older flit, pointer on a tie) and route it by the steering bit
    always_comb begin
        tie        = in0_valid & in1_valid & (age0 == age1);
        pick1      = in1_valid & (~in0_valid | (age1 > age0) | (tie & ptr));
        win_flit   = pick1 ? in1_flit  : in0_flit;
        lose_flit  = pick1 ? in0_flit  : in1_flit;
        lose_valid = pick1 ? in0_valid : in1_valid;
        steer      = win_flit[DIR_LSB + SEL_BIT];
        out0_flit  = in0_flit;
        out1_flit  = in1_flit;
        out0_valid = 1'b0;
        out1_valid = 1'b0;
        if (in0_valid | in1_valid) begin
            if (steer == OUT_IDX0) begin
                out0_flit  = win_flit;
                out0_valid = 1'b1;
                out1_flit  = lose_flit;
                out1_valid = lose_valid;
            end else if (steer == OUT_IDX1) begin
                out1_flit  = win_flit;
                out1_valid = 1'b1;
                out0_flit  = lose_flit;
                out0_valid = lose_valid;
            end
        end
    end

    // Round-robin pointer flips only when this node actually breaks an age tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= 1'b0;
        else        ptr <= ptr ^ tie;
    end

endmodule

// File: rtl/pipelined_permutation_engine.sv
// Two-stage butterfly of 2x2 deflection nodes with optional mid register,
// registered outputs, age increment and a saturating deflection counter.
module pipelined_permutation_engine
    import router_pkg::*;
#(
    parameter int FLIT_W   = 32,
    parameter int DIR_LSB  = 4,
    parameter int AGE_LSB  = 8,
    parameter int AGE_W    = 4,
    parameter int PIPE_MID = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] in_flit_n,
    input  logic [FLIT_W-1:0] in_flit_e,
    input  logic [FLIT_W-1:0] in_flit_s,
    input  logic [FLIT_W-1:0] in_flit_w,
    input  logic              in_valid_n,
    input  logic              in_valid_e,
    input  logic              in_valid_s,
    input  logic              in_valid_w,
    output logic [FLIT_W-1:0] out_flit_n,
    output logic [FLIT_W-1:0] out_flit_e,
    output logic [FLIT_W-1:0] out_flit_s,
    output logic [FLIT_W-1:0] out_flit_w,
    output logic              out_valid_n,
    output logic              out_valid_e,
    output logic              out_valid_s,
    output logic              out_valid_w,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  defl_cnt
);

    // Age +1, held at the all-ones ceiling; every other bit is untouched
    function automatic logic [FLIT_W-1:0] age_inc(input logic [FLIT_W-1:0] f);
        logic [AGE_W-1:0]  a;
        logic [FLIT_W-1:0] r;
        a = f[AGE_LSB +: AGE_W];
        r = f;
        if (a != {AGE_W{1'b1}}) r[AGE_LSB +: AGE_W] = a + 1'b1;
        return r;
    endfunction

    // Counter add that sticks at the maximum instead of wrapping
    function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] c,
                                                 input logic [2:0]       n);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W-2){1'b0}}, n};
        if (s[CNT_W]) return {CNT_W{1'b1}};
        return s[CNT_W-1:0];
    endfunction

    // Stage-1 node outputs: [0]=A.out0 [1]=A.out1 [2]=B.out0 [3]=B.out1
    logic [FLIT_W-1:0] flit_p0 [NUM_PORTS];
    logic              vld_p0  [NUM_PORTS];
    logic [FLIT_W-1:0] flit_p1 [NUM_PORTS];
    logic              vld_p1  [NUM_PORTS];
    // Stage-2 outputs indexed by direction
    logic [FLIT_W-1:0] flit_p2 [NUM_PORTS];
    logic              vld_p2  [NUM_PORTS];
    logic [FLIT_W-1:0] out_flit_r [NUM_PORTS];
    logic              out_vld_r  [NUM_PORTS];
    logic [2:0]        n_defl;
    logic [CNT_W-1:0]  cnt_r;

    // ---- stage 1: A(N,E), B(S,W) steer on dest bit 0 ----
    perm_node #(.FLIT_W(FLIT_W), .DIR_LSB(DIR_LSB), .AGE_LSB(AGE_LSB), .AGE_W(AGE_W), .SEL_BIT(0)) u_node_a (
        .clk(clk), .rst_n(rst_n),
        .in0_flit(in_flit_n), .in0_valid(in_valid_n),
        .in1_flit(in_flit_e), .in1_valid(in_valid_e),
        .out0_flit(flit_p0[0]), .out0_valid(vld_p0[0]),
        .out1_flit(flit_p0[1]), .out1_valid(vld_p0[1])
    );

    perm_node #(.FLIT_W(FLIT_W), .DIR_LSB(DIR_LSB), .AGE_LSB(AGE_LSB), .AGE_W(AGE_W), .SEL_BIT(0)) u_node_b (
        .clk(clk), .rst_n(rst_n),
        .in0_flit(in_flit_s), .in0_valid(in_valid_s),
        .in1_flit(in_flit_w), .in1_valid(in_valid_w),
        .out0_flit(flit_p0[2]), .out0_valid(vld_p0[2]),
        .out1_flit(flit_p0[3]), .out1_valid(vld_p0[3])
    );

    // ---- stage 1 / stage 2 boundary ----
    generate
        if (PIPE_MID != 0) begin : g_mid_reg
            // Optional register between the two node stages
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        flit_p1[i] <= '0;
                        vld_p1[i]  <= 1'b0;
                    end
                end else begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        flit_p1[i] <= flit_p0[i];
                        vld_p1[i]  <= vld_p0[i];
                    end
                end
            end
        end else begin : g_mid_wire
            // Stage 2 reads stage 1 directly
            always_comb begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    flit_p1[i] = flit_p0[i];
                    vld_p1[i]  = vld_p0[i];
                end
            end
        end
    endgenerate

    // ---- stage 2: C -> (N,S), D -> (E,W) steer on dest bit 1 ----
    perm_node #(.FLIT_W(FLIT_W), .DIR_LSB(DIR_LSB), .AGE_LSB(AGE_LSB), .AGE_W(AGE_W), .SEL_BIT(1)) u_node_c (
        .clk(clk), .rst_n(rst_n),
        .in0_flit(flit_p1[0]), .in0_valid(vld_p1[0]),
        .in1_flit(flit_p1[2]), .in1_valid(vld_p1[2]),
        .out0_flit(flit_p2[DIR_N]), .out0_valid(vld_p2[DIR_N]),
        .out1_flit(flit_p2[DIR_S]), .out1_valid(vld_p2[DIR_S])
    );

    perm_node #(.FLIT_W(FLIT_W), .DIR_LSB(DIR_LSB), .AGE_LSB(AGE_LSB), .AGE_W(AGE_W), .SEL_BIT(1)) u_node_d (
        .clk(clk), .rst_n(rst_n),
        .in0_flit(flit_p1[1]), .in0_valid(vld_p1[1]),
        .in1_flit(flit_p1[3]), .in1_valid(vld_p1[3]),
        .out0_flit(flit_p2[DIR_E]), .out0_valid(vld_p2[DIR_E]),
        .out1_flit(flit_p2[DIR_W]), .out1_valid(vld_p2[DIR_W])
    );

    // Count valid flits landing on a port other than the one they asked for
    always_comb begin
        n_defl = 3'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (vld_p2[i] && (flit_p2[i][DIR_LSB +: 2] != 2'(i))) n_defl = n_defl + 3'd1;
        end
    end

    // ---- output register ----
    // Register outputs with aged flits; invalid ports carry all zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                out_flit_r[i] <= '0;
                out_vld_r[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                out_flit_r[i] <= vld_p2[i] ? age_inc(flit_p2[i]) : '0;
                out_vld_r[i]  <= vld_p2[i];
            end
        end
    end

    // Deflection counter; clear wins over this cycle's deflections
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_r <= '0;
        else if (clr_cnt) cnt_r <= '0;
        else              cnt_r <= cnt_add(cnt_r, n_defl);
    end

    assign out_flit_n  = out_flit_r[DIR_N];
    assign out_flit_e  = out_flit_r[DIR_E];
    assign out_flit_s  = out_flit_r[DIR_S];
    assign out_flit_w  = out_flit_r[DIR_W];
    assign out_valid_n = out_vld_r[DIR_N];
    assign out_valid_e = out_vld_r[DIR_E];
    assign out_valid_s = out_vld_r[DIR_S];
    assign out_valid_w = out_vld_r[DIR_W];
    assign defl_cnt    = cnt_r;

endmodule

// File: tb/tb_pipelined_permutation_engine.sv
// Scoreboard bench: two engines (mid register on / off) share the flit inputs;
// each has its own reset, clear and expected-response queue.
module tb_pipelined_permutation_engine;

    typedef struct packed {
        logic [3:0][31:0] f;
        logic [3:0]       v;
        logic [15:0]      d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n1 = 1'b0;
    logic        rst_n0 = 1'b0;
    logic        clr1 = 1'b0;
    logic        clr0 = 1'b0;
    logic [31:0] in_n = '0, in_e = '0, in_s = '0, in_w = '0;
    logic [3:0]  in_v = '0;
    logic [31:0] o1_f [4];
    logic [3:0]  o1_v;
    logic [15:0] d1;
    logic [31:0] o0_f [4];
    logic [3:0]  o0_v;
    logic [15:0] d0;

    exp_t q1[$];
    exp_t q0[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    pipelined_permutation_engine #(.PIPE_MID(1)) dut1 (
        .clk(clk), .rst_n(rst_n1),
        .in_flit_n(in_n), .in_flit_e(in_e), .in_flit_s(in_s), .in_flit_w(in_w),
        .in_valid_n(in_v[0]), .in_valid_e(in_v[1]), .in_valid_s(in_v[2]), .in_valid_w(in_v[3]),
        .out_flit_n(o1_f[0]), .out_flit_e(o1_f[1]), .out_flit_s(o1_f[2]), .out_flit_w(o1_f[3]),
        .out_valid_n(o1_v[0]), .out_valid_e(o1_v[1]), .out_valid_s(o1_v[2]), .out_valid_w(o1_v[3]),
        .clr_cnt(clr1), .defl_cnt(d1)
    );

    pipelined_permutation_engine #(.PIPE_MID(0)) dut0 (
        .clk(clk), .rst_n(rst_n0),
        .in_flit_n(in_n), .in_flit_e(in_e), .in_flit_s(in_s), .in_flit_w(in_w),
        .in_valid_n(in_v[0]), .in_valid_e(in_v[1]), .in_valid_s(in_v[2]), .in_valid_w(in_v[3]),
        .out_flit_n(o0_f[0]), .out_flit_e(o0_f[1]), .out_flit_s(o0_f[2]), .out_flit_w(o0_f[3]),
        .out_valid_n(o0_v[0]), .out_valid_e(o0_v[1]), .out_valid_s(o0_v[2]), .out_valid_w(o0_v[3]),
        .clr_cnt(clr0), .defl_cnt(d0)
    );

    // Flit layout: payload [31:16], age [11:8], desired port [5:4]
    function automatic logic [31:0] mk(input logic [15:0] pl, input logic [1:0] dst, input logic [3:0] age);
        return {pl, 4'h0, age, 2'b00, dst, 4'h0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic send(input logic [31:0] fn, fe, fs, fw, input logic [3:0] iv,
                        input logic [31:0] en, ee, es, ew, input logic [3:0] ev,
                        input int dc1, input int dc0, input bit to1, input bit to0);
        exp_t e;
        in_n = fn; in_e = fe; in_s = fs; in_w = fw; in_v = iv;
        e.f = {ew, es, ee, en};
        e.v = ev;
        e.d = 16'(dc1);
        if (to1) q1.push_back(e);
        e.d = 16'(dc0);
        if (to0) q0.push_back(e);
        @(posedge clk); #1;
        in_v = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor for the engine with the mid register
    always @(negedge clk) begin
        if (|o1_v) begin
            if (q1.size() == 0) chk("unexpected_out_pipe1", {28'h0, o1_v}, 32'h0);
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("pipe1_valid", {28'h0, o1_v}, {28'h0, e.v});
                for (int i = 0; i < 4; i++) chk($sformatf("pipe1_flit%0d", i), o1_f[i], e.f[i]);
                chk("pipe1_defl", {16'h0, d1}, {16'h0, e.d});
            end
        end
    end

    // Monitor for the engine without the mid register
    always @(negedge clk) begin
        if (|o0_v) begin
            if (q0.size() == 0) chk("unexpected_out_pipe0", {28'h0, o0_v}, 32'h0);
            else begin
                exp_t e;
                e = q0.pop_front();
                chk("pipe0_valid", {28'h0, o0_v}, {28'h0, e.v});
                for (int i = 0; i < 4; i++) chk($sformatf("pipe0_flit%0d", i), o0_f[i], e.f[i]);
                chk("pipe0_defl", {16'h0, d0}, {16'h0, e.d});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 100000", $time);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid1", {28'h0, o1_v}, 32'h0);
        chk("reset_valid0", {28'h0, o0_v}, 32'h0);
        chk("reset_defl1", {16'h0, d1}, 32'h0);
        chk("reset_defl0", {16'h0, d0}, 32'h0);
        rst_n1 = 1'b1;
        rst_n0 = 1'b1;

        // Single N flit to W: age 2 -> 3, no deflection
        send(mk(16'h1001, 2'd3, 4'd2), '0, '0, '0, 4'b0001,
             '0, '0, '0, mk(16'h1001, 2'd3, 4'd3), 4'b1000, 0, 0, 1, 1);
        idle(4);

        // Older N wins port E; E flit deflected to N
        send(mk(16'h2001, 2'd1, 4'd5), mk(16'h2002, 2'd1, 4'd3), '0, '0, 4'b0011,
             mk(16'h2002, 2'd1, 4'd4), mk(16'h2001, 2'd1, 4'd6), '0, '0, 4'b0011, 1, 1, 1, 1);
        idle(4);

        // Age tie on consecutive cycles: N wins first, E wins second
        send(mk(16'h3001, 2'd1, 4'd4), mk(16'h3002, 2'd1, 4'd4), '0, '0, 4'b0011,
             mk(16'h3002, 2'd1, 4'd5), mk(16'h3001, 2'd1, 4'd5), '0, '0, 4'b0011, 2, 2, 1, 1);
        send(mk(16'h3003, 2'd1, 4'd4), mk(16'h3004, 2'd1, 4'd4), '0, '0, 4'b0011,
             mk(16'h3003, 2'd1, 4'd5), mk(16'h3004, 2'd1, 4'd5), '0, '0, 4'b0011, 3, 3, 1, 1);
        idle(4);

        // Saturated age stays at 15
        send('0, '0, mk(16'h4001, 2'd2, 4'd15), '0, 4'b0100,
             '0, '0, mk(16'h4001, 2'd2, 4'd15), '0, 4'b0100, 3, 3, 1, 1);
        idle(4);

        // Four flits, two deflections
        send(mk(16'h5001, 2'd2, 4'd1), mk(16'h5002, 2'd0, 4'd2), mk(16'h5003, 2'd3, 4'd3), mk(16'h5004, 2'd1, 4'd0), 4'b1111,
             mk(16'h5002, 2'd0, 4'd3), mk(16'h5001, 2'd2, 4'd2), mk(16'h5004, 2'd1, 4'd1), mk(16'h5003, 2'd3, 4'd4), 4'b1111,
             5, 5, 1, 1);
        idle(4);

        // Clear coincides with the cycle the two deflections register
        clr0 = 1'b1;
        send(mk(16'h5001, 2'd2, 4'd1), mk(16'h5002, 2'd0, 4'd2), mk(16'h5003, 2'd3, 4'd3), mk(16'h5004, 2'd1, 4'd0), 4'b1111,
             mk(16'h5002, 2'd0, 4'd3), mk(16'h5001, 2'd2, 4'd2), mk(16'h5004, 2'd1, 4'd1), mk(16'h5003, 2'd3, 4'd4), 4'b1111,
             0, 0, 1, 1);
        clr0 = 1'b0;
        clr1 = 1'b1;
        idle(1);
        clr1 = 1'b0;
        idle(4);

        // Counting resumes after the clear
        send(mk(16'h6001, 2'd1, 4'd5), mk(16'h6002, 2'd1, 4'd3), '0, '0, 4'b0011,
             mk(16'h6002, 2'd1, 4'd4), mk(16'h6001, 2'd1, 4'd6), '0, '0, 4'b0011, 1, 1, 1, 1);
        idle(4);

        // Reset the piped engine while four flits sit in its mid register
        send(mk(16'h7001, 2'd2, 4'd1), mk(16'h7002, 2'd0, 4'd2), mk(16'h7003, 2'd3, 4'd3), mk(16'h7004, 2'd1, 4'd0), 4'b1111,
             mk(16'h7002, 2'd0, 4'd3), mk(16'h7001, 2'd2, 4'd2), mk(16'h7004, 2'd1, 4'd1), mk(16'h7003, 2'd3, 4'd4), 4'b1111,
             0, 3, 0, 1);
        rst_n1 = 1'b0;
        #1;
        chk("midreset_valid1", {28'h0, o1_v}, 32'h0);
        chk("midreset_defl1", {16'h0, d1}, 32'h0);
        #2;
        rst_n1 = 1'b1;
        idle(5);

        // Inputs accepted again after reset
        send(mk(16'h8001, 2'd3, 4'd2), '0, '0, '0, 4'b0001,
             '0, '0, '0, mk(16'h8001, 2'd3, 4'd3), 4'b1000, 0, 3, 1, 1);
        idle(5);

        chk("pending_pipe1", 32'(q1.size()), 32'h0);
        chk("pending_pipe0", 32'(q0.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
